// File: rtl/microcontroller_pkg.sv
// Shared definitions for the microcontroller system: program-loader FSM states
// and the bus widths used between the loader and the core.
`timescale 1ns/1ps
package microcontroller_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    PRE_RST,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    POST_RST,
    ERROR
  } loaderState_e;

endpackage

// File: rtl/program_loader.sv
// Parses a sync / word-count / payload byte stream and feeds it into the
// microcontroller program memory, then restarts the CPU at address 0.
`timescale 1ns/1ps
module program_loader
  import microcontroller_pkg::*;
#(
  parameter int                MAX_WORDS  = 256,
  parameter int                RST_CYCLES = 1,
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] programIN,
  output logic              LMin,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW  = $clog2(MAX_WORDS + 1);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [WORD_W-1:0] MAX_COUNT = WORD_W'(MAX_WORDS);
  localparam logic [RCW-1:0]    RST_LOAD  = RCW'(RST_CYCLES - 1);

  loaderState_e      state_q;
  logic [BYTE_W-1:0] cntHi_q;
  logic [BYTE_W-1:0] dataHi_q;
  logic [CW-1:0]     wordCnt_q;
  logic [RCW-1:0]    rstCnt_q;
  logic              postWait_q;
  logic              haltHold_q;
  logic [WORD_W-1:0] programIN_q;
  logic              lmIn_q;
  logic              cpuReset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rxReady_q;

  logic              fire;
  logic [WORD_W-1:0] rxCount;

  assign fire    = rx_valid & rxReady_q;
  assign rxCount = {cntHi_q, rx_data};

  // haltHold_q keeps the CPU halted after a rejected frame until a good
  // frame has been fully loaded and its closing reset pulse has finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cntHi_q     <= '0;
      dataHi_q    <= '0;
      wordCnt_q   <= '0;
      rstCnt_q    <= '0;
      postWait_q  <= 1'b0;
      haltHold_q  <= 1'b0;
      programIN_q <= '0;
      lmIn_q      <= 1'b0;
      cpuReset_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rxReady_q   <= 1'b0;
    end else begin
      lmIn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rxReady_q  <= 1'b1;
          cpuReset_q <= haltHold_q;
          if (fire && rx_data == SYNC_BYTE) begin
            state_q    <= PRE_RST;
            rxReady_q  <= 1'b0;
            cpuReset_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rstCnt_q   <= RST_LOAD;
          end
        end
        PRE_RST: begin
          if (rstCnt_q == '0) begin
            state_q    <= CNT_HI;
            rxReady_q  <= 1'b1;
            cpuReset_q <= haltHold_q;
          end else begin
            rstCnt_q <= rstCnt_q - RCW'(1);
          end
        end
        CNT_HI: begin
          if (fire) begin
            cntHi_q <= rx_data;
            state_q <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (fire) begin
            if (rxCount == '0) begin
              state_q    <= POST_RST;
              rxReady_q  <= 1'b0;
              postWait_q <= 1'b1;
            end else if (rxCount > MAX_COUNT) begin
              state_q    <= ERROR;
              rxReady_q  <= 1'b0;
              cpuReset_q <= 1'b1;
              haltHold_q <= 1'b1;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q   <= DATA_HI;
              wordCnt_q <= rxCount[CW-1:0];
            end
          end
        end
        DATA_HI: begin
          if (fire) begin
            dataHi_q <= rx_data;
            state_q  <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (fire) begin
            programIN_q <= {dataHi_q, rx_data};
            lmIn_q      <= 1'b1;
            wordCnt_q   <= wordCnt_q - CW'(1);
            if (wordCnt_q == CW'(1)) begin
              state_q    <= POST_RST;
              rxReady_q  <= 1'b0;
              postWait_q <= 1'b1;
            end else begin
              state_q <= DATA_HI;
            end
          end
        end
        // First cycle lets the final LMin strobe retire before reset rises.
        POST_RST: begin
          if (postWait_q) begin
            postWait_q <= 1'b0;
            cpuReset_q <= 1'b1;
            rstCnt_q   <= RST_LOAD;
          end else if (rstCnt_q == '0) begin
            state_q    <= IDLE;
            cpuReset_q <= 1'b0;
            haltHold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rxReady_q  <= 1'b1;
          end else begin
            rstCnt_q <= rstCnt_q - RCW'(1);
          end
        end
        ERROR: begin
          state_q   <= IDLE;
          rxReady_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ready  = rxReady_q;
  assign programIN = programIN_q;
  assign LMin      = lmIn_q;
  assign cpu_reset = cpuReset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, gaps, rejected counts, mid-frame
// reset and in-payload sync bytes, each with hand-computed expected words.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] programIN;
  logic        LMin;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int numChecks = 0;
  int numErrors = 0;

  logic [7:0]  txQ[$];
  logic [15:0] expQ[$];
  logic [15:0] lmQ[$];
  int rstCycles = 0;
  int overlap   = 0;
  int lmBase, rstBase, overlapBase;

  always #5 clk = ~clk;

  program_loader dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .programIN(programIN),
    .LMin     (LMin),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Records every program-memory write and every cycle the CPU is held in reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (LMin) lmQ.push_back(programIN);
      if (cpu_reset) rstCycles++;
      if (LMin && cpu_reset) overlap++;
    end
  end

  task automatic startMonitor();
    lmBase      = lmQ.size();
    rstBase     = rstCycles;
    overlapBase = overlap;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      numChecks++;
      numErrors++;
      $display("[TB] FAIL rxReadyTimeout: got rx_ready=0, expected 1 for byte %h", b);
    end else begin
      @(negedge clk);
    end
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic sendQueue(input bit withGaps);
    foreach (txQ[i]) applyStimulus(txQ[i], withGaps ? ((i * 3 + 1) % 4) : 0);
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (!(done || err) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(done || err)) begin
      numChecks++;
      numErrors++;
      $display("[TB] FAIL frameTimeout: got done=0 err=0, expected one of them set");
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    numChecks++;
    if ({programIN, LMin, cpu_reset, busy, done, err, rx_ready} !== {16'h0000, 6'b010000}) begin
      numErrors++;
      $display("[TB] FAIL resetValues: got pin=%h lm=%b cr=%b busy=%b done=%b err=%b rdy=%b, expected 0000 0 1 0 0 0 0",
               programIN, LMin, cpu_reset, busy, done, err, rx_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    numChecks++;
    if (cpu_reset !== 1'b0 || rx_ready !== 1'b1) begin
      numErrors++;
      $display("[TB] FAIL resetRelease: got cr=%b rdy=%b, expected cr=0 rdy=1", cpu_reset, rx_ready);
    end
  endtask

  task automatic test_frame(input bit withGaps);
    startMonitor();
    txQ  = '{8'hA5, 8'h00, 8'h06, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h01,
             8'hE3, 8'h08, 8'h00, 8'h00, 8'hE0, 8'h07};
    expQ = '{16'h0005, 16'hEC10, 16'h0001, 16'hE308, 16'h0000, 16'hE007};
    applyStimulus(txQ[0], 0);
    numChecks++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL preReset: got busy=%b cr=%b rdy=%b, expected 1 1 0", busy, cpu_reset, rx_ready);
    end
    txQ.pop_front();
    sendQueue(withGaps);
    waitIdle();
    numChecks++;
    if (lmQ.size() - lmBase != expQ.size()) begin
      numErrors++;
      $display("[TB] FAIL strobeCount gaps=%0d: got %0d, expected %0d", withGaps, lmQ.size() - lmBase, expQ.size());
    end
    for (int i = 0; i < expQ.size() && lmBase + i < lmQ.size(); i++) begin
      numChecks++;
      if (lmQ[lmBase + i] !== expQ[i]) begin
        numErrors++;
        $display("[TB] FAIL word%0d gaps=%0d: got %h, expected %h", i, withGaps, lmQ[lmBase + i], expQ[i]);
      end
    end
    numChecks++;
    if (rstCycles - rstBase != 2 || overlap - overlapBase != 0) begin
      numErrors++;
      $display("[TB] FAIL cpuResetPulses gaps=%0d: got %0d cycles overlap %0d, expected 2 cycles overlap 0",
               withGaps, rstCycles - rstBase, overlap - overlapBase);
    end
    numChecks++;
    if ({done, err, cpu_reset, busy, rx_ready} !== 5'b10001) begin
      numErrors++;
      $display("[TB] FAIL frameEnd gaps=%0d: got done=%b err=%b cr=%b busy=%b rdy=%b, expected 1 0 0 0 1",
               withGaps, done, err, cpu_reset, busy, rx_ready);
    end
  endtask

  task automatic test_empty_frame();
    startMonitor();
    txQ = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00};
    sendQueue(1'b0);
    waitIdle();
    numChecks++;
    if (lmQ.size() - lmBase != 0 || rstCycles - rstBase != 2) begin
      numErrors++;
      $display("[TB] FAIL emptyFrame: got %0d strobes %0d reset cycles, expected 0 strobes 2 reset cycles",
               lmQ.size() - lmBase, rstCycles - rstBase);
    end
    numChecks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL emptyFrameDone: got done=%b err=%b, expected 1 0", done, err);
    end
  endtask

  task automatic test_oversize();
    startMonitor();
    txQ = '{8'hA5, 8'h01, 8'h01};
    sendQueue(1'b0);
    waitIdle();
    repeat (5) @(negedge clk);
    numChecks++;
    if ({err, done, cpu_reset, rx_ready} !== 4'b1011 || lmQ.size() != lmBase) begin
      numErrors++;
      $display("[TB] FAIL oversize: got err=%b done=%b cr=%b rdy=%b strobes=%0d, expected 1 0 1 1 0",
               err, done, cpu_reset, rx_ready, lmQ.size() - lmBase);
    end
    startMonitor();
    txQ = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    sendQueue(1'b0);
    waitIdle();
    numChecks++;
    if ({done, err, cpu_reset} !== 3'b100) begin
      numErrors++;
      $display("[TB] FAIL recoverAfterErr: got done=%b err=%b cr=%b, expected 1 0 0", done, err, cpu_reset);
    end
    numChecks++;
    if (lmQ.size() - lmBase != 1 || (lmQ.size() > lmBase && lmQ[lmBase] !== 16'h1234)) begin
      numErrors++;
      $display("[TB] FAIL recoverWord: got %0d strobes, expected one strobe of 1234", lmQ.size() - lmBase);
    end
  endtask

  task automatic test_mid_reset();
    txQ = '{8'hA5, 8'h00, 8'h06, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h00, 8'h01};
    sendQueue(1'b0);
    numChecks++;
    if (LMin !== 1'b1 || programIN !== 16'h0001) begin
      numErrors++;
      $display("[TB] FAIL thirdWord: got lm=%b pin=%h, expected 1 0001", LMin, programIN);
    end
    reset = 1'b1;
    #1;
    numChecks++;
    if ({programIN, LMin, cpu_reset, busy, done, err, rx_ready} !== {16'h0000, 6'b010000}) begin
      numErrors++;
      $display("[TB] FAIL midReset: got pin=%h lm=%b cr=%b busy=%b done=%b err=%b rdy=%b, expected 0000 0 1 0 0 0 0",
               programIN, LMin, cpu_reset, busy, done, err, rx_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_frame(1'b0);
  endtask

  task automatic test_sync_in_payload();
    startMonitor();
    txQ  = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h12, 8'h34};
    expQ = '{16'hA5A5, 16'h1234};
    sendQueue(1'b0);
    waitIdle();
    numChecks++;
    if (lmQ.size() - lmBase != 2) begin
      numErrors++;
      $display("[TB] FAIL syncPayloadCount: got %0d, expected 2", lmQ.size() - lmBase);
    end
    for (int i = 0; i < 2 && lmBase + i < lmQ.size(); i++) begin
      numChecks++;
      if (lmQ[lmBase + i] !== expQ[i]) begin
        numErrors++;
        $display("[TB] FAIL syncPayloadWord%0d: got %h, expected %h", i, lmQ[lmBase + i], expQ[i]);
      end
    end
    numChecks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      numErrors++;
      $display("[TB] FAIL syncPayloadDone: got done=%b err=%b, expected 1 0", done, err);
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_empty_frame();
    test_oversize();
    test_mid_reset();
    test_sync_in_payload();
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
